// File: rtl/bcd_conv_sched.sv
// Shared round-robin binary-to-BCD (double-dabble) converter for the countdown displays.
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits with code 4'hF.

// Handshake properties for the converter outputs, kept apart from the datapath.
module bcd_conv_sched_chk #(
    parameter int N_REQ = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] gnt,
    input  logic             busy,
    input  logic             done
);

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_gnt_busy:   assert property (@(posedge clk) disable iff (!rst_n) (|gnt) |-> busy);
    a_done_busy:  assert property (@(posedge clk) disable iff (!rst_n) done |-> busy);
    a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);
    a_gnt_pulse:  assert property (@(posedge clk) disable iff (!rst_n) (|gnt) |=> (gnt == {N_REQ{1'b0}}));

endmodule

module bcd_conv_sched #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     gnt,
    output logic                 busy,
    output logic                 done,
    output logic [ID_W-1:0]      done_id,
    output logic [3:0]           hundreds,
    output logic [3:0]           tens,
    output logic [3:0]           units
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DONE  = 3'd3
    } state_t;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [3:0] HUN_RST = 4'hF;
    localparam logic [3:0] TEN_RST = 4'hF;
`else
    localparam logic [3:0] HUN_RST = 4'h0;
    localparam logic [3:0] TEN_RST = 4'h0;
`endif

    state_t           state_r;
    logic [ID_W-1:0]  winner_r;
    logic [ID_W-1:0]  last_r;
    logic [ID_W-1:0]  done_id_r;
    logic [N_REQ-1:0] gnt_r;
    logic             busy_r;
    logic             done_r;
    logic [3:0]       hun_r;
    logic [3:0]       ten_r;
    logic [3:0]       uni_r;
    logic [19:0]      sr_r;
    logic [2:0]       cnt_r;

    logic             any_req_s;
    logic [ID_W-1:0]  winner_s;
    logic [N_REQ-1:0] gnt_nxt_s;
    int               best_dist_s;
    int               dist_s;
    logic [7:0]       op_sel_s;
    logic [19:0]      sr_adj_s;
    logic [19:0]      sr_nxt_s;
    logic [3:0]       hun_raw_s;
    logic [3:0]       ten_raw_s;
    logic [3:0]       uni_raw_s;
    logic [3:0]       hun_s;
    logic [3:0]       ten_s;

    function automatic logic [3:0] add3(input logic [3:0] nib);
        if (nib > 4'd4) begin
            return nib + 4'd3;
        end else begin
            return nib;
        end
    endfunction

    // Round-robin pick: requester with the smallest circular distance past the last one served.
    always_comb begin
        any_req_s   = |req;
        winner_s    = last_r;
        best_dist_s = N_REQ;
        dist_s      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            dist_s = (i + N_REQ - 1 - int'(last_r)) % N_REQ;
            if (req[i] && (dist_s < best_dist_s)) begin
                best_dist_s = dist_s;
                winner_s    = ID_W'(i);
            end else begin
                best_dist_s = best_dist_s;
            end
        end
    end

    // Grant vector for the pending winner and operand mux for the registered winner.
    always_comb begin
        gnt_nxt_s = {N_REQ{1'b0}};
        op_sel_s  = 8'd0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner_s == ID_W'(i)) begin
                gnt_nxt_s[i] = 1'b1;
            end else begin
                gnt_nxt_s[i] = 1'b0;
            end
            if (winner_r == ID_W'(i)) begin
                op_sel_s = req_data[8*i +: 8];
            end else begin
                op_sel_s = op_sel_s;
            end
        end
    end

    // One double-dabble step on {hundreds,tens,units,operand}; nibble tests use pre-add values.
    always_comb begin
        sr_adj_s  = {add3(sr_r[19:16]), add3(sr_r[15:12]), add3(sr_r[11:8]), sr_r[7:0]};
        sr_nxt_s  = sr_adj_s << 5'd1;
        hun_raw_s = sr_nxt_s[19:16];
        ten_raw_s = sr_nxt_s[15:12];
        uni_raw_s = sr_nxt_s[11:8];
`ifdef LEADING_ZERO_BLANK_EN
        if (hun_raw_s == 4'd0) begin
            hun_s = 4'hF;
        end else begin
            hun_s = hun_raw_s;
        end
        if ((hun_raw_s == 4'd0) && (ten_raw_s == 4'd0)) begin
            ten_s = 4'hF;
        end else begin
            ten_s = ten_raw_s;
        end
`else
        hun_s = hun_raw_s;
        ten_s = ten_raw_s;
`endif
    end

    // Control FSM; every handshake and digit output is driven from a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            winner_r  <= {ID_W{1'b0}};
            last_r    <= ID_W'(N_REQ - 1);
            gnt_r     <= {N_REQ{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            done_id_r <= {ID_W{1'b0}};
            hun_r     <= HUN_RST;
            ten_r     <= TEN_RST;
            uni_r     <= 4'd0;
            sr_r      <= 20'd0;
            cnt_r     <= 3'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (any_req_s) begin
                        winner_r <= winner_s;
                        gnt_r    <= gnt_nxt_s;
                        busy_r   <= 1'b1;
                        state_r  <= ST_LOAD;
                    end else begin
                        gnt_r    <= {N_REQ{1'b0}};
                        busy_r   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    sr_r    <= {12'd0, op_sel_s};
                    cnt_r   <= 3'd0;
                    last_r  <= winner_r;
                    gnt_r   <= {N_REQ{1'b0}};
                    state_r <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    sr_r  <= sr_nxt_s;
                    cnt_r <= cnt_r + 3'd1;
                    if (cnt_r == 3'd7) begin
                        state_r   <= ST_DONE;
                        done_r    <= 1'b1;
                        done_id_r <= winner_r;
                        hun_r     <= hun_s;
                        ten_r     <= ten_s;
                        uni_r     <= uni_raw_s;
                    end else begin
                        state_r   <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    gnt_r   <= {N_REQ{1'b0}};
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt      = gnt_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign done_id  = done_id_r;
    assign hundreds = hun_r;
    assign tens     = ten_r;
    assign units    = uni_r;

    bcd_conv_sched_chk #(.N_REQ(N_REQ)) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .gnt   (gnt_r),
        .busy  (busy_r),
        .done  (done_r)
    );

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Scoreboard bench for bcd_conv_sched: issued conversions queue their expected digits,
// a negedge monitor pops and compares on every done pulse.
module tb_bcd_conv_sched;

    localparam int N_REQ = 2;
    localparam int ID_W  = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_REQ-1:0] req;
    logic [15:0]      req_data;
    logic [N_REQ-1:0] gnt;
    logic             busy;
    logic             done;
    logic [ID_W-1:0]  done_id;
    logic [3:0]       hundreds;
    logic [3:0]       tens;
    logic [3:0]       units;

    bcd_conv_sched #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .busy     (busy),
        .done     (done),
        .done_id  (done_id),
        .hundreds (hundreds),
        .tens     (tens),
        .units    (units)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int h;
        int t;
        int u;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   rr_last  = N_REQ - 1;
    bit   gap_chk  = 1'b0;
    bit   prev_done = 1'b0;
    bit   last_done_vld = 1'b0;
    int   last_done_cyc = 0;
    int   last_gnt_cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Decimal digits by plain arithmetic, with leading-zero blanking in that build.
    function automatic exp_t ref_model(input int id, input int d);
        exp_t e;
        e.id = id;
        e.h  = d / 100;
        e.t  = (d / 10) % 10;
        e.u  = d % 10;
`ifdef LEADING_ZERO_BLANK_EN
        if (e.h == 0) begin
            e.h = 15;
            if (e.t == 0) e.t = 15;
        end
`endif
        return e;
    endfunction

    task automatic check_reset_vals();
        exp_t r;
        r = ref_model(0, 0);
        check("rst_gnt", int'(gnt), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_done_id", int'(done_id), 0);
        check("rst_hundreds", int'(hundreds), r.h);
        check("rst_tens", int'(tens), r.t);
        check("rst_units", int'(units), 0);
    endtask

    // Monitor: compare every completion against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_done     <= 1'b0;
            last_done_vld <= 1'b0;
        end else begin
            if (gnt != '0) last_gnt_cyc <= cyc;
            if (done) begin
                check("done_width", int'(prev_done), 0);
                check("gnt_to_done", cyc - last_gnt_cyc, 9);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: done_id %0d with empty scoreboard (cycle %0d)", done_id, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("done_id", int'(done_id), e.id);
                    check("hundreds", int'(hundreds), e.h);
                    check("tens", int'(tens), e.t);
                    check("units", int'(units), e.u);
                end
                if (gap_chk && last_done_vld) check("done_gap", cyc - last_done_cyc, 11);
                last_done_vld <= 1'b1;
                last_done_cyc <= cyc;
            end else if (prev_done) begin
                check("busy_after_done", int'(busy), 0);
            end
            if (!gap_chk) last_done_vld <= 1'b0;
            prev_done <= done;
        end
    end

    // Drive a request, predict the round-robin winner, wait for its grant, leave one cycle later.
    task automatic issue(input logic [1:0] mask, input logic [7:0] d0, input logic [7:0] d1,
                         input bit hold, output int gcyc);
        int  w;
        int  m;
        bit  seen;
        req      = mask;
        req_data = {d1, d0};
        m = int'(mask);
        w = -1;
        for (int k = 1; k <= N_REQ; k++) begin
            if ((w < 0) && (((m >> ((rr_last + k) % N_REQ)) & 1) == 1)) w = (rr_last + k) % N_REQ;
        end
        exp_q.push_back(ref_model(w, (w == 0) ? int'(d0) : int'(d1)));
        seen = 1'b0;
        gcyc = 0;
        for (int n = 0; (n < 40) && !seen; n++) begin
            @(negedge clk);
            if (gnt != '0) begin
                seen = 1'b1;
                gcyc = cyc;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL gnt_timeout: no grant for requester %0d within 40 cycles", w);
        end else begin
            check("gnt_onehot", int'(gnt), 1 << w);
        end
        rr_last = w;
        @(negedge clk);
        if (!hold) req = '0;
    endtask

    task automatic drain();
        bool_wait: for (int n = 0; n < 200; n++) begin
            if ((exp_q.size() == 0) && !busy) break;
            @(negedge clk);
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        int g;
        int prev_g;
        int c0;
        logic [1:0] m;
        rst_n    = 1'b0;
        req      = '0;
        req_data = '0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        @(negedge clk);

        // Full-scale operand, grant latency from an idle engine.
        c0 = cyc;
        issue(2'b01, 8'd255, 8'd0, 1'b0, g);
        check("gnt_latency", g - c0, 1);
        drain();

        // Zero operand from requester 1.
        issue(2'b10, 8'd0, 8'd0, 1'b0, g);
        drain();

        // Both held: strict alternation, back-to-back completions.
        gap_chk = 1'b1;
        repeat (4) issue(2'b11, 8'd87, 8'd120, 1'b1, g);
        req = '0;
        drain();
        gap_chk = 1'b0;

        // Operand change after capture is ignored.
        issue(2'b01, 8'd9, 8'd0, 1'b1, g);
        req_data = {8'd0, 8'd200};
        repeat (3) @(negedge clk);
        req = '0;
        drain();

        // Sweep every operand on requester 0 with req held throughout.
        gap_chk = 1'b1;
        prev_g  = 0;
        for (int v = 0; v < 256; v++) begin
            issue(2'b01, 8'(v), 8'd0, 1'b1, g);
            if (v > 0) check("regrant_gap", g - prev_g, 11);
            prev_g = g;
        end
        req = '0;
        drain();

        // Random request masks and operands.
        for (int i = 0; i < 30; i++) begin
            m = 2'($urandom_range(1, 3));
            issue(m, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, g);
        end
        drain();
        gap_chk = 1'b0;

        // Reset during the fifth shift cycle discards the result and restores priority.
        issue(2'b01, 8'd123, 8'd0, 1'b0, g);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_vals();
        repeat (12) @(negedge clk);
        check("done_in_reset", int'(done), 0);
        rst_n   = 1'b1;
        rr_last = N_REQ - 1;
        @(negedge clk);
        issue(2'b11, 8'd50, 8'd60, 1'b0, g);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
